cpu_sequencer: RTL and testbench
================================

Name: cpu_sequencer

Overview:
Fetch/execute controller that sits directly upstream of the ALU. It owns the program counter, instruction register and carry flag, and fetches 16-bit instructions from a synchronous instruction ROM. It presents the held instruction to the ALU and issues the one-cycle exec1 strobe. It executes branch/halt opcodes itself and stalls IN/OUT instructions on a valid/ready handshake with the I/O ports.

Parameters:
PC_W, 8, program counter / instruction address width (ROM depth 2^PC_W)
RESET_PC, 0, PC value loaded on reset

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
imem_addr  output  PC_W  instruction ROM address (ROM registers the address, data valid next cycle)
imem_rdata  input  16  instruction ROM read data
instr  output  16  instruction register contents, driven to ALU instr
exec1  output  1  execute strobe to ALU, one cycle per instruction
carrystatus  output  1  carry flag, driven to ALU carrystatus
carryout  input  1  ALU carry result
carryen  input  1  ALU carry-write enable (already gated by exec1)
in_valid  input  1  input port has data; source holds it until accepted
in_ready  output  1  input data consumed this cycle
out_valid  output  1  ALU output data valid this cycle
out_ready  input  1  output sink can accept
halted  output  1  sequencer stopped in HALT

Behaviour:
- Reset (any state, mid-instruction included): state=FETCH, pc=RESET_PC, IR=16'h0000, carrystatus=0. exec1, in_ready, out_valid and halted are 0. imem_addr=RESET_PC.
- Opcodes are IR[15:8]. F8–FF are ALU/register ops, executed by the ALU. FC=IN, FD=OUT. F4=JMP, F5=JC, F6=JNC, F7=HALT. All other values are NOP.
- FETCH: imem_addr=pc. Next state is LOAD.
- LOAD: IR<=imem_rdata. Next state is chosen from imem_rdata[15:8]:
  - FC: WAIT_IN
  - FD: WAIT_OUT
  - F7: HALT
  - otherwise: EXEC
- WAIT_IN: stays while in_valid=0. Moves to EXEC in the first cycle with in_valid=1.
- WAIT_OUT: stays while out_ready=0. Moves to EXEC in the first cycle with out_ready=1.
- EXEC (exactly one cycle): exec1=1.
  - in_ready=1 iff op=FC. out_valid=1 iff op=FD. The sink samples OUT data in this cycle; out_ready is guaranteed still high.
  - If carryen=1, carrystatus<=carryout at the clock edge ending EXEC. Otherwise carrystatus holds.
  - pc update:
    - JMP: pc<=IR[PC_W-1:0]
    - JC: pc<=IR[PC_W-1:0] if carrystatus=1, else pc+1
    - JNC: the inverse of JC
    - all others: pc+1
  - The branch condition uses carrystatus before any same-cycle update.
  - Next state is FETCH.
- HALT: halted=1, exec1=0, pc and IR frozen. Only reset leaves HALT.
- Minimum instruction latency is 3 cycles (FETCH, LOAD, EXEC); IN/OUT add the stall cycles.
- pc+1 wraps modulo 2^PC_W (2^PC_W−1 → 0). A jump target is truncated to PC_W bits.
- instr output is the IR at all times, including during stalls, so ALU register-select outputs are stable before exec1.
- in_valid/out_ready are ignored outside WAIT_IN/WAIT_OUT/EXEC. Input data is never consumed without exec1.
- carryen/carryout are ignored when exec1=0.

Decomposition:
- Shared package cpu_pkg:
  - opcode constants: OP_JMP=8'hF4, OP_JC=8'hF5, OP_JNC=8'hF6, OP_HALT=8'hF7, OP_IN=8'hFC, OP_OUT=8'hFD
  - ALU op range base 8'hF8
  - state encoding localparams FETCH/LOAD/WAIT_IN/WAIT_OUT/EXEC/HALT
- Single module; no sub-module. The pc/IR/flag datapath and the FSM are small enough to stay inline.

Test Plan:
- Reset then ROM[0]=F800 (ADD), carryout=0, carryen=0 → exec1 high in cycle 3 only, with instr=16'hF800. imem_addr goes 0→1. carrystatus stays 0.
- ROM[0]=F803 with carryout=1, carryen=1 in EXEC, then ROM[1]=F505 (JC 5) → carrystatus=1 after the first EXEC. Next fetch address after the JC is 5. With the flag clear, the same JC fetches address 2.
- ROM[3]=FC40 (IN), in_valid held low 4 cycles then high → state WAIT_IN for 4 cycles. Then one cycle with exec1=1 and in_ready=1, then FETCH of address 4.
- ROM[4]=FD10 (OUT), out_ready low 2 cycles → out_valid=1 coincident with exec1 only after out_ready=1. No exec1 during the stall.
- PC_W=8, ROM[255]=0000 (NOP) → next imem_addr=0. ROM[0]=F700 → halted=1, exec1 never asserts again. Assert reset → halted=0, imem_addr=0.
- Assert reset during WAIT_OUT and during EXEC → next cycle state=FETCH, pc=0, carrystatus=0, exec1=0, out_valid=0.

Source files
------------

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared opcode constants and sequencer state encoding.
//   Opcodes live in instruction bits [15:8]. F8..FF go to the ALU, FC/FD are
//   the port ops, F4..F7 are control ops executed by the sequencer itself.
package cpu_pkg;

  localparam logic [7:0] OP_JMP      = 8'hF4;
  localparam logic [7:0] OP_JC       = 8'hF5;
  localparam logic [7:0] OP_JNC      = 8'hF6;
  localparam logic [7:0] OP_HALT     = 8'hF7;
  localparam logic [7:0] OP_ALU_BASE = 8'hF8;
  localparam logic [7:0] OP_IN       = 8'hFC;
  localparam logic [7:0] OP_OUT      = 8'hFD;

  typedef enum logic [2:0] {
    FETCH    = 3'd0,
    LOAD     = 3'd1,
    WAIT_IN  = 3'd2,
    WAIT_OUT = 3'd3,
    EXEC     = 3'd4,
    HALT     = 3'd5
  } state_t;

endpackage

// File: rtl/cpu_sequencer.sv
// cpu_sequencer: fetch/execute controller in front of the ALU.
//   Owns pc, instruction register and carry flag. Fetches from a synchronous
//   ROM (address registered, data one cycle later), holds the instruction on
//   instr, pulses exec1 once per instruction, executes JMP/JC/JNC/HALT and
//   stalls IN/OUT on the port handshakes.
// Ports:
//   clk, reset         clock, synchronous active-high reset
//   imem_addr/rdata    instruction ROM address out / data in
//   instr, exec1       held instruction and execute strobe to the ALU
//   carrystatus        carry flag to the ALU; carryout/carryen update it
//   in_valid/in_ready  input port handshake (in_ready only in EXEC of IN)
//   out_valid/ready    output port handshake (out_valid only in EXEC of OUT)
//   halted             high while stopped in HALT
module cpu_sequencer
  import cpu_pkg::*;
#(
  parameter int              PC_W     = 8,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset,
  output logic [PC_W-1:0] imem_addr,
  input  logic [15:0]     imem_rdata,
  output logic [15:0]     instr,
  output logic            exec1,
  output logic            carrystatus,
  input  logic            carryout,
  input  logic            carryen,
  input  logic            in_valid,
  output logic            in_ready,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            halted
);

  state_t          state, state_nxt;
  logic [PC_W-1:0] pc, pc_nxt;
  logic [15:0]     ir;
  logic [7:0]      op;
  logic            take_branch;

  assign op          = ir[15:8];
  assign instr       = ir;
  // pc only moves at the end of EXEC, so it is already the fetch address
  // whenever the FSM is in FETCH.
  assign imem_addr   = pc;

  // Branch condition reads the flag as it stood before this EXEC's update.
  always_comb begin
    take_branch = 1'b0;
    case (op)
      OP_JMP:  take_branch = 1'b1;
      OP_JC:   take_branch = carrystatus;
      OP_JNC:  take_branch = ~carrystatus;
      default: take_branch = 1'b0;
    endcase
  end

  assign pc_nxt = take_branch ? ir[PC_W-1:0] : pc + PC_W'(1);

  always_comb begin
    state_nxt = state;
    exec1     = 1'b0;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    halted    = 1'b0;
    case (state)
      FETCH: state_nxt = LOAD;
      LOAD: begin
        // Decode straight from ROM data; IR is being loaded on this edge.
        case (imem_rdata[15:8])
          OP_IN:   state_nxt = WAIT_IN;
          OP_OUT:  state_nxt = WAIT_OUT;
          OP_HALT: state_nxt = HALT;
          default: state_nxt = EXEC;
        endcase
      end
      WAIT_IN:  if (in_valid)  state_nxt = EXEC;
      WAIT_OUT: if (out_ready) state_nxt = EXEC;
      EXEC: begin
        exec1     = 1'b1;
        in_ready  = (op == OP_IN);
        out_valid = (op == OP_OUT);
        state_nxt = FETCH;
      end
      HALT:    halted = 1'b1;
      default: state_nxt = FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= FETCH;
      pc          <= RESET_PC;
      ir          <= '0;
      carrystatus <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == LOAD) ir <= imem_rdata;
      if (exec1) begin
        pc <= pc_nxt;
        if (carryen) carrystatus <= carryout;
      end
    end
  end

endmodule

// File: tb/tb_cpu_sequencer.sv
module tb_cpu_sequencer;
  typedef struct packed {
    logic [15:0] instr;
    logic        in_ready;
    logic        out_valid;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  imem_addr;
  logic [15:0] imem_rdata;
  logic [15:0] instr;
  logic        exec1, carrystatus, carryout, carryen;
  logic        in_valid, in_ready, out_valid, out_ready, halted;

  logic [15:0] rom [256];
  exp_t        sbq [$];
  int          errors = 0;
  int          checks = 0;

  cpu_sequencer #(.PC_W(8), .RESET_PC(8'd0)) dut (
    .clk(clk), .reset(reset), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .instr(instr), .exec1(exec1), .carrystatus(carrystatus),
    .carryout(carryout), .carryen(carryen), .in_valid(in_valid),
    .in_ready(in_ready), .out_valid(out_valid), .out_ready(out_ready),
    .halted(halted)
  );

  always #5 clk = ~clk;

  // Synchronous ROM: address registered, data valid the following cycle.
  always @(posedge clk) imem_rdata <= rom[imem_addr];

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    reset = 1'b1;
    tick;
    reset = 1'b0;
  endtask

  task automatic rom_clear;
    for (int i = 0; i < 256; i++) rom[i] = 16'h0000;
  endtask

  // Bounded wait for the next exec1 pulse; cyc = cycles waited.
  task automatic wait_exec(input int budget, output int cyc, output bit ok);
    cyc = 0;
    while (exec1 !== 1'b1 && cyc < budget) begin
      tick;
      cyc++;
    end
    ok = (exec1 === 1'b1);
  endtask

  task automatic sb_pop(output exp_t e, output bit have);
    if (sbq.size() > 0) begin
      e = sbq.pop_front();
      have = 1'b1;
    end else begin
      e = '0;
      have = 1'b0;
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; carryen = 1'b1; carryout = 1'b1;
    in_valid = 1'b1; out_ready = 1'b1;
    tick; tick;
    checks++;
    if ({exec1, in_ready, out_valid, halted} !== 4'b0000) begin
      errors++; $display("FAIL reset_strobes got=%b exp=0000", {exec1, in_ready, out_valid, halted});
    end
    checks++;
    if (imem_addr !== 8'd0) begin
      errors++; $display("FAIL reset_addr got=%h exp=00", imem_addr);
    end
    checks++;
    if (instr !== 16'h0000) begin
      errors++; $display("FAIL reset_instr got=%h exp=0000", instr);
    end
    checks++;
    if (carrystatus !== 1'b0) begin
      errors++; $display("FAIL reset_carry got=%b exp=0", carrystatus);
    end
    reset = 1'b0; carryen = 1'b0; carryout = 1'b0;
    in_valid = 1'b0; out_ready = 1'b0;
  endtask

  task automatic test_alu;
    int cyc; bit ok, have; exp_t e;
    rom_clear;
    rom[0] = 16'hF800;
    sbq.push_back('{16'hF800, 1'b0, 1'b0});
    do_reset;
    checks++;
    if (imem_addr !== 8'd0) begin
      errors++; $display("FAIL alu_fetch_addr got=%h exp=00", imem_addr);
    end
    wait_exec(10, cyc, ok); sb_pop(e, have);
    checks++;
    if (!ok || !have || {instr, in_ready, out_valid} !== e) begin
      errors++; $display("FAIL alu_exec got=%h exp=%h ok=%0d", {instr, in_ready, out_valid}, e, ok);
    end
    checks++;
    if (cyc != 2) begin
      errors++; $display("FAIL alu_latency got=%0d exp=2", cyc);
    end
    tick;
    checks++;
    if ({exec1, imem_addr} !== {1'b0, 8'd1}) begin
      errors++; $display("FAIL alu_next got=%h exp=001", {exec1, imem_addr});
    end
    checks++;
    if (carrystatus !== 1'b0) begin
      errors++; $display("FAIL alu_carry got=%b exp=0", carrystatus);
    end
  endtask

  task automatic test_carry_branch;
    int cyc; bit ok, have; exp_t e;
    logic [15:0] prog_a [2];
    logic [7:0]  nxt_a  [2];
    logic [15:0] prog_b [5];
    logic [7:0]  nxt_b  [5];
    prog_a = '{16'hF505, 16'hF609};
    nxt_a  = '{8'd5, 8'd6};
    prog_b = '{16'hF505, 16'hF607, 16'hF4FE, 16'h0000, 16'h0000};
    nxt_b  = '{8'd2, 8'd7, 8'hFE, 8'hFF, 8'h00};

    // Flag set: JC 5 taken, then JNC 9 falls through to 6.
    rom_clear;
    rom[0] = 16'hF803; rom[1] = 16'hF505; rom[5] = 16'hF609;
    sbq.push_back('{16'hF803, 1'b0, 1'b0});
    foreach (prog_a[i]) sbq.push_back('{prog_a[i], 1'b0, 1'b0});
    carryen = 1'b1; carryout = 1'b1;
    do_reset;
    wait_exec(10, cyc, ok); sb_pop(e, have);
    checks++;
    if (!ok || !have || {instr, in_ready, out_valid} !== e) begin
      errors++; $display("FAIL carry_set_exec got=%h exp=%h", {instr, in_ready, out_valid}, e);
    end
    tick;
    carryen = 1'b0; carryout = 1'b0;
    checks++;
    if (carrystatus !== 1'b1) begin
      errors++; $display("FAIL carry_set got=%b exp=1", carrystatus);
    end
    for (int i = 0; i < 2; i++) begin
      wait_exec(10, cyc, ok); sb_pop(e, have);
      checks++;
      if (!ok || !have || {instr, in_ready, out_valid} !== e) begin
        errors++; $display("FAIL branch_a_exec%0d got=%h exp=%h", i, {instr, in_ready, out_valid}, e);
      end
      tick;
      checks++;
      if (imem_addr !== nxt_a[i]) begin
        errors++; $display("FAIL branch_a_addr%0d got=%h exp=%h", i, imem_addr, nxt_a[i]);
      end
    end

    // Flag clear: carryen high outside EXEC must not touch the flag.
    // JC falls through, JNC taken, JMP to FE, then FE->FF->00 wrap.
    rom_clear;
    rom[0] = 16'hF803; rom[1] = 16'hF505; rom[2] = 16'hF607; rom[7] = 16'hF4FE;
    sbq.push_back('{16'hF803, 1'b0, 1'b0});
    foreach (prog_b[i]) sbq.push_back('{prog_b[i], 1'b0, 1'b0});
    carryen = 1'b1; carryout = 1'b1;
    do_reset;
    wait_exec(10, cyc, ok);
    carryen = 1'b0;
    sb_pop(e, have);
    checks++;
    if (!ok || !have || {instr, in_ready, out_valid} !== e) begin
      errors++; $display("FAIL carry_clr_exec got=%h exp=%h", {instr, in_ready, out_valid}, e);
    end
    tick;
    checks++;
    if (carrystatus !== 1'b0) begin
      errors++; $display("FAIL carry_gated got=%b exp=0", carrystatus);
    end
    for (int i = 0; i < 5; i++) begin
      wait_exec(10, cyc, ok); sb_pop(e, have);
      checks++;
      if (!ok || !have || {instr, in_ready, out_valid} !== e) begin
        errors++; $display("FAIL branch_b_exec%0d got=%h exp=%h", i, {instr, in_ready, out_valid}, e);
      end
      tick;
      checks++;
      if (imem_addr !== nxt_b[i]) begin
        errors++; $display("FAIL branch_b_addr%0d got=%h exp=%h", i, imem_addr, nxt_b[i]);
      end
    end
    carryout = 1'b0;
  endtask

  task automatic test_in;
    int cyc; bit ok, have; exp_t e;
    rom_clear;
    rom[0] = 16'hF403; rom[3] = 16'hFC40;
    sbq.push_back('{16'hF403, 1'b0, 1'b0});
    sbq.push_back('{16'hFC40, 1'b1, 1'b0});
    in_valid = 1'b1;  // ignored outside WAIT_IN / IN exec
    do_reset;
    wait_exec(10, cyc, ok); sb_pop(e, have);
    checks++;
    if (!ok || !have || {instr, in_ready, out_valid} !== e) begin
      errors++; $display("FAIL in_jmp_exec got=%h exp=%h", {instr, in_ready, out_valid}, e);
    end
    in_valid = 1'b0;
    tick; tick; tick;  // FETCH 3, LOAD, first WAIT_IN cycle
    for (int k = 0; k < 4; k++) begin
      checks++;
      if ({exec1, in_ready, instr} !== {2'b00, 16'hFC40}) begin
        errors++; $display("FAIL in_stall%0d got=%h exp=0fc40", k, {exec1, in_ready, instr});
      end
      if (k == 3) in_valid = 1'b1;
      tick;
    end
    wait_exec(2, cyc, ok); sb_pop(e, have);
    checks++;
    if (!ok || cyc != 0 || !have || {instr, in_ready, out_valid} !== e) begin
      errors++; $display("FAIL in_exec got=%h exp=%h cyc=%0d", {instr, in_ready, out_valid}, e, cyc);
    end
    in_valid = 1'b0;
    tick;
    checks++;
    if ({exec1, in_ready, imem_addr} !== {2'b00, 8'd4}) begin
      errors++; $display("FAIL in_next got=%h exp=004", {exec1, in_ready, imem_addr});
    end
  endtask

  task automatic test_out;
    int cyc; bit ok, have; exp_t e;
    rom_clear;
    rom[0] = 16'hF404; rom[4] = 16'hFD10;
    sbq.push_back('{16'hF404, 1'b0, 1'b0});
    sbq.push_back('{16'hFD10, 1'b0, 1'b1});
    out_ready = 1'b1;
    do_reset;
    wait_exec(10, cyc, ok); sb_pop(e, have);
    checks++;
    if (!ok || !have || {instr, in_ready, out_valid} !== e) begin
      errors++; $display("FAIL out_jmp_exec got=%h exp=%h", {instr, in_ready, out_valid}, e);
    end
    out_ready = 1'b0;
    tick; tick; tick;  // FETCH 4, LOAD, first WAIT_OUT cycle
    for (int k = 0; k < 2; k++) begin
      checks++;
      if ({exec1, out_valid} !== 2'b00) begin
        errors++; $display("FAIL out_stall%0d got=%b exp=00", k, {exec1, out_valid});
      end
      if (k == 1) out_ready = 1'b1;
      tick;
    end
    wait_exec(2, cyc, ok); sb_pop(e, have);
    checks++;
    if (!ok || cyc != 0 || !have || {instr, in_ready, out_valid} !== e) begin
      errors++; $display("FAIL out_exec got=%h exp=%h cyc=%0d", {instr, in_ready, out_valid}, e, cyc);
    end
    tick;
    out_ready = 1'b0;
    checks++;
    if ({exec1, out_valid, imem_addr} !== {2'b00, 8'd5}) begin
      errors++; $display("FAIL out_next got=%h exp=005", {exec1, out_valid, imem_addr});
    end
  endtask

  task automatic test_halt_wrap;
    int cyc; bit ok, have; exp_t e;
    rom_clear;
    rom[0] = 16'hF4FF;
    sbq.push_back('{16'hF4FF, 1'b0, 1'b0});
    sbq.push_back('{16'h0000, 1'b0, 1'b0});
    do_reset;
    for (int i = 0; i < 2; i++) begin
      wait_exec(10, cyc, ok); sb_pop(e, have);
      checks++;
      if (!ok || !have || {instr, in_ready, out_valid} !== e) begin
        errors++; $display("FAIL halt_pre_exec%0d got=%h exp=%h", i, {instr, in_ready, out_valid}, e);
      end
      if (i == 0) rom[0] = 16'hF700;
      tick;
    end
    checks++;
    if (imem_addr !== 8'd0) begin
      errors++; $display("FAIL wrap_addr got=%h exp=00", imem_addr);
    end
    tick; tick;  // LOAD, then HALT
    for (int k = 0; k < 8; k++) begin
      checks++;
      if ({halted, exec1, imem_addr, instr} !== {2'b10, 8'd0, 16'hF700}) begin
        errors++; $display("FAIL halt_hold%0d got=%h exp=200f700", k, {halted, exec1, imem_addr, instr});
      end
      tick;
    end
    reset = 1'b1;
    tick;
    reset = 1'b0;
    checks++;
    if ({halted, exec1, imem_addr} !== 10'd0) begin
      errors++; $display("FAIL halt_reset got=%h exp=000", {halted, exec1, imem_addr});
    end
  endtask

  task automatic test_reset_mid;
    int cyc; bit ok, have; exp_t e;
    rom_clear;
    rom[0] = 16'hF800; rom[1] = 16'hFD00;
    sbq.push_back('{16'hF800, 1'b0, 1'b0});
    carryen = 1'b1; carryout = 1'b1; out_ready = 1'b0;
    do_reset;
    wait_exec(10, cyc, ok); sb_pop(e, have);
    checks++;
    if (!ok || !have || {instr, in_ready, out_valid} !== e) begin
      errors++; $display("FAIL rmid_exec got=%h exp=%h", {instr, in_ready, out_valid}, e);
    end
    tick;
    carryen = 1'b0;
    tick; tick; tick;  // LOAD, WAIT_OUT, WAIT_OUT
    checks++;
    if ({carrystatus, exec1, instr} !== {2'b10, 16'hFD00}) begin
      errors++; $display("FAIL rmid_pre_wait got=%h exp=2fd00", {carrystatus, exec1, instr});
    end
    reset = 1'b1;
    tick;
    reset = 1'b0;
    checks++;
    if ({exec1, out_valid, carrystatus, imem_addr, instr} !== 27'd0) begin
      errors++; $display("FAIL rmid_wait_reset got=%h exp=0", {exec1, out_valid, carrystatus, imem_addr, instr});
    end

    // Reset landing on the OUT exec cycle, with a carry write pending.
    sbq.push_back('{16'hF800, 1'b0, 1'b0});
    sbq.push_back('{16'hFD00, 1'b0, 1'b1});
    carryen = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      wait_exec(10, cyc, ok); sb_pop(e, have);
      checks++;
      if (!ok || !have || {instr, in_ready, out_valid} !== e) begin
        errors++; $display("FAIL rmid_exec%0d got=%h exp=%h", i, {instr, in_ready, out_valid}, e);
      end
      if (i == 0) tick;
    end
    reset = 1'b1;
    tick;
    reset = 1'b0;
    checks++;
    if ({exec1, out_valid, carrystatus, imem_addr, instr} !== 27'd0) begin
      errors++; $display("FAIL rmid_exec_reset got=%h exp=0", {exec1, out_valid, carrystatus, imem_addr, instr});
    end
    carryen = 1'b0; carryout = 1'b0; out_ready = 1'b0;
  endtask

  initial begin
    reset = 1'b1; carryout = 1'b0; carryen = 1'b0;
    in_valid = 1'b0; out_ready = 1'b0;
    rom_clear;
    test_reset;
    test_alu;
    test_carry_branch;
    test_in;
    test_out;
    test_halt_wrap;
    test_reset_mid;
    checks++;
    if (sbq.size() != 0) begin
      errors++; $display("FAIL scoreboard_drain got=%0d exp=0", sbq.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
